// File: rtl/dom_tb_pkg.sv
// rtl/dom_tb_pkg.sv - shared constants, state encoding and GF(2^2) golden multiply
package dom_tb_pkg;

    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_2468;

    typedef logic [1:0] fsmStateT;
    localparam fsmStateT ST_IDLE  = 2'd0;
    localparam fsmStateT ST_DRIVE = 2'd1;
    localparam fsmStateT ST_DRAIN = 2'd2;
    localparam fsmStateT ST_DONE  = 2'd3;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
        logic [1:0] expv;
    } pipeT;

    function automatic int shareBits(input int shares);
        return 2 * shares;
    endfunction

    function automatic int zBits(input int shares);
        return shares * (shares - 1);
    endfunction

    // X masks, then Y masks, then Z, packed LSB-first
    function automatic int rndBits(input int shares);
        return 4 * (shares - 1) + shares * (shares - 1);
    endfunction

    // Canright normal basis; 3 is the multiplicative identity
    function automatic logic [1:0] gf4_nb_mul(input logic [1:0] a, input logic [1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

endpackage

// File: rtl/dom_mul_gf2_stim_checker_if.sv
// rtl/dom_mul_gf2_stim_checker_if.sv - checker <-> multiplier harness signal bundle
interface dom_mul_gf2_stim_checker_if #(parameter int SHARES = 3);
    logic                         StartxSI;
    logic                         BusyxSO;
    logic                         DonexSO;
    logic [2*SHARES-1:0]          _XxDO;
    logic [2*SHARES-1:0]          _YxDO;
    logic [SHARES*(SHARES-1)-1:0] _ZxDO;
    logic [2*SHARES-1:0]          _BxDO;
    logic [2*SHARES-1:0]          _QxDI;
    logic [4:0]                   ErrCntxDO;
    logic [3:0]                   FirstErrxDO;
    logic                         FirstErrVldxSO;

    modport master (
        input  StartxSI, _QxDI,
        output BusyxSO, DonexSO, _XxDO, _YxDO, _ZxDO, _BxDO,
               ErrCntxDO, FirstErrxDO, FirstErrVldxSO
    );

    modport slave (
        output StartxSI, _QxDI,
        input  BusyxSO, DonexSO, _XxDO, _YxDO, _ZxDO, _BxDO,
               ErrCntxDO, FirstErrxDO, FirstErrVldxSO
    );
endinterface

// File: rtl/dom_share_lfsr.sv
// rtl/dom_share_lfsr.sv - 32-bit Galois LFSR with a wrapped wide output slice
module dom_share_lfsr
    import dom_tb_pkg::*;
#(
    parameter logic [31:0] SEED = LFSR_SEED_DEFAULT,
    parameter int          OUTW = 32
) (
    input  logic            ClkxCI,
    input  logic            RstxRI,
    input  logic            EnxSI,
    output logic [OUTW-1:0] RndxDO
);

    logic [31:0] stateq;

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            stateq <= SEED;
        end else if (EnxSI) begin
            stateq <= (stateq >> 1) ^ (stateq[0] ? LFSR_POLY : 32'd0);
        end
    end

    // Slices wider than the state reuse the state bits from bit 0 again
    for (genvar k = 0; k < OUTW; k++) begin : g_slice
        assign RndxDO[k] = stateq[k % 32];
    end

endmodule

// File: rtl/dom_mul_gf2_stim_checker.sv
// rtl/dom_mul_gf2_stim_checker.sv - masked GF(2^2) sweep source and recombining result checker
module dom_mul_gf2_stim_checker
    import dom_tb_pkg::*;
#(
    parameter int          SHARES    = 3,
    parameter int          LATENCY   = 1,
    parameter bit          MASK_EN   = 1'b1,
    parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input logic                         ClkxCI,
    input logic                         RstxRI,
    dom_mul_gf2_stim_checker_if.master  bus
);

    localparam int SW = shareBits(SHARES);
    localparam int ZW = zBits(SHARES);
    localparam int RW = rndBits(SHARES);

    fsmStateT        stateq;
    logic [3:0]      pairq;
    logic [3:0]      drainq;
    logic [SW-1:0]   xq, yq;
    logic [ZW-1:0]   zq;
    logic [4:0]      errCntq;
    logic [3:0]      firstErrq;
    logic            firstVldq;
    pipeT            pipeq [LATENCY];

    logic            startOk, loadPair, mismatch;
    logic [3:0]      pairNext;
    logic [RW-1:0]   rnd;
    logic [SW-1:0]   xSh, ySh;
    logic [ZW-1:0]   zSh;
    logic [1:0]      qSum;
    pipeT            pipeHead, pipeTail;

    assign startOk  = ((stateq == ST_IDLE) || (stateq == ST_DONE)) && bus.StartxSI;
    // Share registers load the pair that the state register enters with,
    // so pair n is on the outputs exactly during DRIVE cycle n
    assign loadPair = startOk || ((stateq == ST_DRIVE) && (pairq != 4'd15));
    assign pairNext = (stateq == ST_DRIVE) ? pairq + 4'd1 : 4'd0;

    dom_share_lfsr #(.SEED(LFSR_SEED), .OUTW(RW)) u_lfsr (
        .ClkxCI (ClkxCI),
        .RstxRI (RstxRI),
        .EnxSI  (loadPair),
        .RndxDO (rnd)
    );

    always_comb begin
        xSh      = '0;
        ySh      = '0;
        zSh      = '0;
        xSh[1:0] = pairNext[3:2];
        ySh[1:0] = pairNext[1:0];
        if (MASK_EN) begin
            for (int k = 1; k < SHARES; k++) begin
                xSh[2*k +: 2] = rnd[2*(k-1) +: 2];
                ySh[2*k +: 2] = rnd[2*(SHARES-1) + 2*(k-1) +: 2];
                xSh[1:0]      = xSh[1:0] ^ rnd[2*(k-1) +: 2];
                ySh[1:0]      = ySh[1:0] ^ rnd[2*(SHARES-1) + 2*(k-1) +: 2];
            end
            zSh = rnd[4*(SHARES-1) +: ZW];
        end
    end

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            stateq <= ST_IDLE;
            pairq  <= 4'd0;
            drainq <= 4'd0;
            xq     <= '0;
            yq     <= '0;
            zq     <= '0;
        end else begin
            case (stateq)
                ST_IDLE, ST_DONE: if (bus.StartxSI) stateq <= ST_DRIVE;
                ST_DRIVE: begin
                    if (pairq == 4'd15) begin
                        stateq <= ST_DRAIN;
                        drainq <= 4'd0;
                    end
                end
                ST_DRAIN: begin
                    if (drainq == 4'(LATENCY - 1)) stateq <= ST_DONE;
                    else                           drainq <= drainq + 4'd1;
                end
                default: stateq <= ST_IDLE;
            endcase
            if (loadPair) pairq <= pairNext;
            xq <= loadPair ? xSh : '0;
            yq <= loadPair ? ySh : '0;
            zq <= loadPair ? zSh : '0;
        end
    end

    assign pipeHead = '{vld:  (stateq == ST_DRIVE),
                        idx:  pairq,
                        expv: gf4_nb_mul(pairq[3:2], pairq[1:0])};
    assign pipeTail = pipeq[LATENCY-1];

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            for (int k = 0; k < LATENCY; k++) pipeq[k] <= '0;
        end else begin
            pipeq[0] <= pipeHead;
            for (int k = 1; k < LATENCY; k++) pipeq[k] <= pipeq[k-1];
        end
    end

    always_comb begin
        qSum = 2'b00;
        for (int k = 0; k < SHARES; k++) qSum = qSum ^ bus._QxDI[2*k +: 2];
    end

    assign mismatch = pipeTail.vld && (qSum != pipeTail.expv);

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            errCntq   <= 5'd0;
            firstErrq <= 4'd0;
            firstVldq <= 1'b0;
        end else if (startOk) begin
            errCntq   <= 5'd0;
            firstErrq <= 4'd0;
            firstVldq <= 1'b0;
        end else if (mismatch) begin
            errCntq <= errCntq + 5'd1;
            if (!firstVldq) begin
                firstErrq <= pipeTail.idx;
                firstVldq <= 1'b1;
            end
        end
    end

    assign bus.BusyxSO        = (stateq == ST_DRIVE) || (stateq == ST_DRAIN);
    assign bus.DonexSO        = (stateq == ST_DONE);
    assign bus._XxDO          = xq;
    assign bus._YxDO          = yq;
    assign bus._ZxDO          = zq;
    assign bus._BxDO          = '0;
    assign bus.ErrCntxDO      = errCntq;
    assign bus.FirstErrxDO    = firstErrq;
    assign bus.FirstErrVldxSO = firstVldq;

endmodule

// File: tb/tb_dom_mul_gf2_stim_checker.sv
// tb/tb_dom_mul_gf2_stim_checker.sv - directed bench with behavioural multiplier models
module tb_dom_mul_gf2_stim_checker;
    import dom_tb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic faultEn = 1'b0;
    int   modelLat = 1;
    int   checks = 0;
    int   failures = 0;
    int   busyCycles;

    always #5 clk = ~clk;

    dom_mul_gf2_stim_checker_if #(.SHARES(3)) bus ();
    dom_mul_gf2_stim_checker_if #(.SHARES(2)) bus0 ();

    dom_mul_gf2_stim_checker #(.SHARES(3), .LATENCY(1), .MASK_EN(1'b1), .LFSR_SEED(32'hACE1_2468)) dut (
        .ClkxCI (clk), .RstxRI (rst), .bus (bus)
    );
    dom_mul_gf2_stim_checker #(.SHARES(2), .LATENCY(1), .MASK_EN(1'b0), .LFSR_SEED(32'hACE1_2468)) dut0 (
        .ClkxCI (clk), .RstxRI (rst), .bus (bus0)
    );

    assign bus.StartxSI  = start;
    assign bus0.StartxSI = start;

    function automatic logic [1:0] tbMul(input logic [1:0] a, input logic [1:0] b);
        case ({a, b})
            4'h5: tbMul = 2'd2;
            4'h6: tbMul = 2'd3;
            4'h7: tbMul = 2'd1;
            4'h9: tbMul = 2'd3;
            4'hA: tbMul = 2'd1;
            4'hB: tbMul = 2'd2;
            4'hD: tbMul = 2'd1;
            4'hE: tbMul = 2'd2;
            4'hF: tbMul = 2'd3;
            default: tbMul = 2'd0;
        endcase
    endfunction

    // Three-share multiplier model: recombine, multiply, re-mask, delay 1 or 2
    logic [1:0] xr, yr, pm;
    logic [3:0] maskq;
    logic [5:0] qComb, q1, q2;
    always_comb begin
        xr    = bus._XxDO[1:0] ^ bus._XxDO[3:2] ^ bus._XxDO[5:4];
        yr    = bus._YxDO[1:0] ^ bus._YxDO[3:2] ^ bus._YxDO[5:4];
        pm    = tbMul(xr, yr) ^ ((faultEn && xr == 2'd2 && yr == 2'd1) ? 2'd1 : 2'd0);
        qComb = {maskq[3:2], maskq[1:0], pm ^ maskq[3:2] ^ maskq[1:0]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= '0; q2 <= '0; maskq <= '0;
        end else begin
            q1 <= qComb; q2 <= q1; maskq <= 4'($urandom);
        end
    end
    assign bus._QxDI = (modelLat == 2) ? q2 : q1;

    logic [3:0] q0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q0 <= '0;
        else     q0 <= {2'b00, tbMul(bus0._XxDO[1:0] ^ bus0._XxDO[3:2], bus0._YxDO[1:0] ^ bus0._YxDO[3:2])};
    end
    assign bus0._QxDI = q0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pulseStart();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Called on the negedge of DRIVE cycle 0; returns on the first non-busy negedge
    task automatic runSweep(input bit firstSweep, output int cyc);
        logic [1:0] s1First;
        bit         s1Changed;
        cyc       = 0;
        s1First   = 2'd0;
        s1Changed = 1'b0;
        while (bus.BusyxSO === 1'b1 && cyc < 100) begin
            if (firstSweep && cyc < 16) begin
                check("xRecomb", 32'(bus._XxDO[1:0] ^ bus._XxDO[3:2] ^ bus._XxDO[5:4]), 32'(cyc >> 2));
                check("yRecomb", 32'(bus._YxDO[1:0] ^ bus._YxDO[3:2] ^ bus._YxDO[5:4]), 32'(cyc & 3));
                check("plainX", 32'(bus0._XxDO), 32'(cyc >> 2));
                check("plainY", 32'(bus0._YxDO), 32'(cyc & 3));
                check("plainZ", 32'(bus0._ZxDO), 32'd0);
                if (cyc == 0) s1First = bus._XxDO[3:2];
                else if (bus._XxDO[3:2] !== s1First) s1Changed = 1'b1;
                if (cyc == 0) begin
                    check("pair0X", 32'(bus._XxDO), 32'h22);
                    check("pair0Y", 32'(bus._YxDO), 32'h1B);
                    check("pair0Z", 32'(bus._ZxDO), 32'h24);
                end
                if (cyc == 1) begin
                    check("pair1X", 32'(bus._XxDO), 32'h11);
                    check("pair1Y", 32'(bus._YxDO), 32'h0E);
                    check("pair1Z", 32'(bus._ZxDO), 32'h12);
                end
            end
            cyc++;
            @(negedge clk);
        end
        if (firstSweep) check("share1Varies", 32'(s1Changed), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rstBusy", 32'(bus.BusyxSO), 32'd0);
        check("rstDone", 32'(bus.DonexSO), 32'd0);
        check("rstX", 32'(bus._XxDO), 32'd0);
        check("rstErrCnt", 32'(bus.ErrCntxDO), 32'd0);
        check("rstFirstVld", 32'(bus.FirstErrVldxSO), 32'd0);
        rst = 1'b0;

        check("gold1x1", 32'(gf4_nb_mul(2'd1, 2'd1)), 32'd2);
        check("gold2x2", 32'(gf4_nb_mul(2'd2, 2'd2)), 32'd1);
        check("gold2x1", 32'(gf4_nb_mul(2'd2, 2'd1)), 32'd3);
        check("gold3x3", 32'(gf4_nb_mul(2'd3, 2'd3)), 32'd3);
        check("gold0x2", 32'(gf4_nb_mul(2'd0, 2'd2)), 32'd0);
        check("gold3x2", 32'(gf4_nb_mul(2'd3, 2'd2)), 32'd2);

        // Ideal multiplier, masked and plaintext instances
        pulseStart();
        runSweep(1'b1, busyCycles);
        check("idealBusyLen", 32'(busyCycles), 32'd17);
        check("idealDone", 32'(bus.DonexSO), 32'd1);
        check("idealErrCnt", 32'(bus.ErrCntxDO), 32'd0);
        check("idealFirstVld", 32'(bus.FirstErrVldxSO), 32'd0);
        check("plainDone", 32'(bus0.DonexSO), 32'd1);
        check("plainErrCnt", 32'(bus0.ErrCntxDO), 32'd0);

        // Wrong product only for X=2, Y=1
        faultEn = 1'b1;
        pulseStart();
        runSweep(1'b0, busyCycles);
        check("faultErrCnt", 32'(bus.ErrCntxDO), 32'd1);
        check("faultFirstErr", 32'(bus.FirstErrxDO), 32'd9);
        check("faultFirstVld", 32'(bus.FirstErrVldxSO), 32'd1);
        repeat (3) @(negedge clk);
        check("holdDone", 32'(bus.DonexSO), 32'd1);
        check("holdErrCnt", 32'(bus.ErrCntxDO), 32'd1);
        faultEn = 1'b0;

        // Model one cycle slower than the checker expects
        modelLat = 2;
        pulseStart();
        runSweep(1'b0, busyCycles);
        check("latErrCnt", 32'(bus.ErrCntxDO), 32'd11);
        check("latFirstErr", 32'(bus.FirstErrxDO), 32'd5);
        check("latFirstVld", 32'(bus.FirstErrVldxSO), 32'd1);

        // Reset in DRIVE cycle 7 while errors are accumulating
        pulseStart();
        repeat (7) @(negedge clk);
        check("preRstErrCnt", 32'(bus.ErrCntxDO), 32'd1);
        rst = 1'b1;
        #1;
        check("midRstBusy", 32'(bus.BusyxSO), 32'd0);
        check("midRstX", 32'(bus._XxDO), 32'd0);
        check("midRstY", 32'(bus._YxDO), 32'd0);
        check("midRstZ", 32'(bus._ZxDO), 32'd0);
        check("midRstErrCnt", 32'(bus.ErrCntxDO), 32'd0);
        check("midRstFirstVld", 32'(bus.FirstErrVldxSO), 32'd0);
        check("midRstFirstErr", 32'(bus.FirstErrxDO), 32'd0);
        @(negedge clk); rst = 1'b0;
        modelLat = 1;
        @(negedge clk);
        check("idleBusy", 32'(bus.BusyxSO), 32'd0);
        check("idleDone", 32'(bus.DonexSO), 32'd0);

        // Start asserted in DRAIN must be ignored
        pulseStart();
        repeat (16) @(negedge clk);
        check("drainBusy", 32'(bus.BusyxSO), 32'd1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("drainStartDone", 32'(bus.DonexSO), 32'd1);
        repeat (2) @(negedge clk);
        check("drainStartHold", 32'(bus.DonexSO), 32'd1);
        check("drainErrCnt", 32'(bus.ErrCntxDO), 32'd0);

        pulseStart();
        runSweep(1'b0, busyCycles);
        check("cleanBusyLen", 32'(busyCycles), 32'd17);
        check("cleanErrCnt", 32'(bus.ErrCntxDO), 32'd0);
        check("cleanFirstVld", 32'(bus.FirstErrVldxSO), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
